clmul16_kara_seq: RTL and testbench



---
 rtl/clmul_pkg.sv | 29 ++
 rtl/clmul8.sv | 20 ++
 rtl/clmul16_kara_seq.sv | 112 +++++++++++
 tb/tb_clmul16_kara_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clmul_pkg.sv
// Shared definitions for the sequenced 16x16 carry-less multiplier.
// Latency: n/a (constants, types and a reference function only).
// Backpressure: n/a.
package clmul_pkg;

    localparam int HALF_W = 8;
    localparam int PP_W   = 15;
    localparam int PROD_W = 31;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Straight shift-and-XOR carry-less product of two 16-bit polynomials.
    function automatic logic [PROD_W-1:0] clmul_ref(input logic [15:0] a,
                                                    input logic [15:0] b);
        logic [PROD_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) r = r ^ ({15'b0, a} << i);
        end
        return r;
    endfunction

endpackage

// File: rtl/clmul8.sv
// Combinational 8x8 -> 15-bit carry-less (GF(2)[x]) multiplier.
// Latency: 0 cycles (pure combinational AND/XOR tree).
// Backpressure: none; output follows inputs.
// Ports: i_a, i_b - 8-bit polynomial operands; o_p - 15-bit product.
module clmul8
    import clmul_pkg::*;
(
    input  logic [HALF_W-1:0] i_a,
    input  logic [HALF_W-1:0] i_b,
    output logic [PP_W-1:0]   o_p
);

    always_comb begin
        o_p = '0;
        for (int i = 0; i < HALF_W; i++) begin
            if (i_b[i]) o_p = o_p ^ ({7'b0, i_a} << i);
        end
    end

endmodule

// File: rtl/clmul16_kara_seq.sv
// Sequenced 16x16 carry-less multiplier: one shared clmul8 across Karatsuba z0, z2, zm.
// Latency: 3 cycles accept->out_valid; initiation interval 5 cycles under no backpressure.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk/rst (async active-high); in_valid/in_ready/a/b operand side;
//        out_valid/out_ready/p product side; busy = not IDLE.
module clmul16_kara_seq
    import clmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       a,
    input  logic [15:0]       b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p,
    output logic              busy
);

    state_t              r_state;
    logic [15:0]         r_a;
    logic [15:0]         r_b;
    logic [PP_W-1:0]     r_z0;
    logic [PP_W-1:0]     r_z2;
    logic [PROD_W-1:0]   r_p;
    logic                r_out_valid;

    logic [HALF_W-1:0]   w_mul_a;
    logic [HALF_W-1:0]   w_mul_b;
    logic [PP_W-1:0]     w_mul;
    logic [PP_W-1:0]     w_z1;
    logic [PROD_W-1:0]   w_p;

    // Operand mux for the single shared multiplier; MUL_MID (and the idle
    // states, where the result is unused) feed the half-sums.
    always_comb begin
        w_mul_a = r_a[HALF_W-1:0] ^ r_a[15:HALF_W];
        w_mul_b = r_b[HALF_W-1:0] ^ r_b[15:HALF_W];
        case (r_state)
            MUL_LO: begin
                w_mul_a = r_a[HALF_W-1:0];
                w_mul_b = r_b[HALF_W-1:0];
            end
            MUL_HI: begin
                w_mul_a = r_a[15:HALF_W];
                w_mul_b = r_b[15:HALF_W];
            end
            default: ;
        endcase
    end

    clmul8 u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_mul)
    );

    // Karatsuba recombination; only meaningful in MUL_MID when w_mul = zm.
    assign w_z1 = w_mul ^ r_z0 ^ r_z2;
    assign w_p  = {16'b0, r_z0}
                ^ ({16'b0, w_z1} << 8)
                ^ ({16'b0, r_z2} << 16);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_z0        <= '0;
            r_z2        <= '0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= MUL_LO;
                    end
                end
                MUL_LO: begin
                    r_z0    <= w_mul;
                    r_state <= MUL_HI;
                end
                MUL_HI: begin
                    r_z2    <= w_mul;
                    r_state <= MUL_MID;
                end
                MUL_MID: begin
                    r_p         <= w_p;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign p         = r_p;

endmodule

// File: tb/tb_clmul16_kara_seq.sv
// Scoreboard bench for clmul16_kara_seq: directed known answers, backpressure,
// mid-operation reset and a long back-to-back random run against clmul_ref.
module tb_clmul16_kara_seq;
    import clmul_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       a;
    logic [15:0]       b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] p;
    logic              busy;

    clmul16_kara_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cnt = 0;

    logic [PROD_W-1:0] exp_q[$];
    int                lat_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: latency check on the first cycle of each out_valid, and
    // scoreboard compare on each output handshake.
    initial begin
        bit prev_vld;
        int t;
        logic [PROD_W-1:0] e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 1'b0;
            end else begin
                if (out_valid && !prev_vld) begin
                    if (lat_q.size() == 0) begin
                        chk(1'b0, "spurious_out_valid", 32'(cyc), 32'hFFFFFFFF);
                    end else begin
                        t = lat_q.pop_front();
                        chk(cyc == t + 3, "latency", 32'(cyc - t), 32'd3);
                    end
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_product", {1'b0, p}, 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk(p === e, "product", {1'b0, p}, {1'b0, e});
                    end
                end
                prev_vld = out_valid;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=%0d required=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Offer an operand pair and wait (bounded) for the accept edge.
    // Returns the accept edge index; push=0 issues without expecting output.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [PROD_W-1:0] e, input bit push,
                         input bit keep, output int acc);
        bit seen;
        int c;
        acc      = -1;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        for (int n = 0; n < 50 && acc < 0; n++) begin
            @(negedge clk);
            seen = in_ready;
            c    = cyc;
            @(posedge clk);
            if (seen) acc = c + 1;
        end
        #1;
        if (acc < 0) begin
            chk(1'b0, "accept_timeout", 32'd0, 32'd1);
        end else if (push) begin
            exp_q.push_back(e);
            lat_q.push_back(acc);
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) done = 1'b1;
        end
        if (!done) chk(1'b0, "drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0]       a;
        logic [15:0]       b;
        logic [PROD_W-1:0] p;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   acc;
        int   prev_acc;
        int   hs0;
        bit   got;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [PROD_W-1:0] e;

        vecs[0] = '{16'h0003, 16'h0003, 31'h00000005};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 31'h55555555};
        vecs[2] = '{16'h8000, 16'h8000, 31'h40000000};
        vecs[3] = '{16'h0100, 16'h0100, 31'h00010000};
        vecs[4] = '{16'h1234, 16'h0001, 31'h00001234};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(out_valid === 1'b0, "reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk(p === '0, "reset_p", {1'b0, p}, 32'd0);
        chk(busy === 1'b0, "reset_busy", {31'b0, busy}, 32'd0);
        chk(in_ready === 1'b1, "reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed known-answer products.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1, 1'b0, acc);
            drain();
        end

        // Backpressure: hold the result for 5 cycles, offer a stray pair.
        out_ready = 1'b0;
        e = clmul_ref(16'hA5C3, 16'h3C5A);
        issue(16'hA5C3, 16'h3C5A, e, 1'b1, 1'b0, acc);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk(got, "bp_out_valid_seen", {31'b0, got}, 32'd1);
        hs0 = hs_cnt;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk(p === e, "bp_p_stable", {1'b0, p}, {1'b0, e});
            chk(in_ready === 1'b0, "bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk(out_valid === 1'b1, "bp_out_valid", {31'b0, out_valid}, 32'd1);
            if (k == 0) begin
                @(posedge clk);
                #1;
                in_valid = 1'b1;
                a        = 16'h0F0F;
                b        = 16'h7777;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(out_valid === 1'b0, "bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk(in_ready === 1'b1, "bp_release_ready", {31'b0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk(hs_cnt == hs0 + 1, "bp_handshakes", 32'(hs_cnt - hs0), 32'd1);
        drain();

        // Reset during MUL_HI abandons the operation.
        issue(16'hBEEF, 16'hCAFE, '0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk(out_valid === 1'b0, "rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk(p === '0, "rst_mid_p", {1'b0, p}, 32'd0);
        chk(busy === 1'b0, "rst_mid_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk(out_valid === 1'b0, "rst_no_result", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        issue(16'h00FF, 16'h00FF, 31'h00005555, 1'b1, 1'b0, acc);
        drain();

        // Back-to-back random pairs with in_valid and out_ready held high.
        prev_acc = -1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            issue(ra, rb, clmul_ref(ra, rb), 1'b1, 1'b1, acc);
            if (prev_acc >= 0)
                chk(acc - prev_acc == 5, "accept_spacing", 32'(acc - prev_acc), 32'd5);
            prev_acc = acc;
        end
        in_valid = 1'b0;
        drain();

        chk(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
